// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, parity positions, TX state and the encoder,
// so the serial transmitter and the detector agree on one codeword layout.
package hamming_pkg;
  localparam int CW_W      = 7;
  localparam int DATA_W    = 4;
  localparam int BIT_CNT_W = 3;
  localparam int P1_IDX    = 0;
  localparam int P2_IDX    = 1;
  localparam int P4_IDX    = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              inject;
    logic [2:0]        error_bit;
  } tx_req_t;

  // cw[i] is Hamming position i+1: {d3,d2,d1,p4,d0,p2,p1}
  function automatic logic [CW_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d,
                                                    input logic              odd);
    logic [CW_W-1:0] cw;
    cw         = {d[3], d[2], d[1], 1'b0, d[0], 1'b0, 1'b0};
    cw[P1_IDX] = d[0] ^ d[1] ^ d[3] ^ odd;
    cw[P2_IDX] = d[0] ^ d[2] ^ d[3] ^ odd;
    cw[P4_IDX] = d[1] ^ d[2] ^ d[3] ^ odd;
    return cw;
  endfunction
endpackage

// File: rtl/hamming74_encode.sv
// Combinational Hamming(7,4) encoder wrapping the shared package function.
module hamming74_encode
  import hamming_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [DATA_W-1:0] data_word,
  output logic [CW_W-1:0]   cw
);
  assign cw = hamming74_enc(data_word, PARITY_ODD);
endmodule

// File: rtl/hamming_serial_tx.sv
// Serial Hamming(7,4) transmitter: accept a nibble, encode, optionally flip one bit,
// shift the codeword out LSB-first under a dataOutgoing strobe, then hold an idle gap.
module hamming_serial_tx
  import hamming_pkg::*;
#(
  parameter int GAP_CYCLES = 5,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              dataValid,
  input  logic [DATA_W-1:0] dataWord,
  input  logic              injectError,
  input  logic [2:0]        errorBit,
  output logic              dataReady,
  output logic              dataOutgoing,
  output logic              dataOut,
  output logic [CW_W-1:0]   codeword,
  output logic              busy,
  output logic              done
);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  tx_req_t              req;
  logic [CW_W-1:0]      enc_cw, flip_mask, tx_cw;

  tx_state_e            state_q, state_d;
  logic [CW_W-2:0]      shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CW_W-1:0]      cw_q, cw_d;
  logic                 out_q, out_d;
  logic                 outgoing_q, outgoing_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign req = '{data: dataWord, inject: injectError, error_bit: errorBit};

  hamming74_encode #(.PARITY_ODD(PARITY_ODD)) u_enc (
    .data_word (req.data),
    .cw        (enc_cw)
  );

  // errorBit counts Hamming positions from 1; 0 means leave the frame clean
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CW_W; i++)
      flip_mask[i] = req.inject && (req.error_bit == 3'(i + 1));
  end

  assign tx_cw     = enc_cw ^ flip_mask;
  assign dataReady = (state_q == ST_IDLE) & resetN;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    cw_d       = cw_q;
    out_d      = out_q;
    outgoing_d = outgoing_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dataValid && dataReady) begin
          cw_d       = tx_cw;
          shift_d    = tx_cw[CW_W-1:1];
          out_d      = tx_cw[0];
          outgoing_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_cnt_q == BIT_CNT_W'(CW_W - 1)) begin
          out_d      = 1'b0;
          outgoing_d = 1'b0;
          done_d     = 1'b1;
          gap_cnt_d  = '0;
          state_d    = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          out_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_GAP: begin
        if (32'(gap_cnt_q) == GAP_CYCLES - 1) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      cw_q       <= '0;
      out_q      <= 1'b0;
      outgoing_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cw_q       <= cw_d;
      out_q      <= out_d;
      outgoing_q <= outgoing_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dataOutgoing = outgoing_q;
  assign dataOut      = out_q;
  assign codeword     = cw_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_hamming_serial_tx.sv
// Scoreboard bench for hamming_serial_tx: driver pushes expected codewords on accept,
// a negedge monitor pops and checks each serial frame, done pulse and gap.
module tb_hamming_serial_tx;
  localparam int G = 5;

  logic       clock, resetN, dataValid, injectError;
  logic [3:0] dataWord;
  logic [2:0] errorBit;
  logic       dataReady, dataOutgoing, dataOut, busy, done;
  logic [6:0] codeword;

  logic       rst2_n, v2;
  logic [3:0] w2;
  logic       ready2, outg2, out2, busy2, done2;
  logic [6:0] cw2;

  hamming_serial_tx #(.GAP_CYCLES(G), .PARITY_ODD(1'b0)) dut (
    .clock(clock), .resetN(resetN), .dataValid(dataValid), .dataWord(dataWord),
    .injectError(injectError), .errorBit(errorBit), .dataReady(dataReady),
    .dataOutgoing(dataOutgoing), .dataOut(dataOut), .codeword(codeword),
    .busy(busy), .done(done)
  );

  hamming_serial_tx #(.GAP_CYCLES(0), .PARITY_ODD(1'b1)) dut_g0 (
    .clock(clock), .resetN(rst2_n), .dataValid(v2), .dataWord(w2),
    .injectError(1'b0), .errorBit(3'd0), .dataReady(ready2),
    .dataOutgoing(outg2), .dataOut(out2), .codeword(cw2),
    .busy(busy2), .done(done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_edge = 1'b0;
  logic [6:0] exp_q[$];
  logic [3:0] g0_words [3] = '{4'b0000, 4'b1011, 4'b1111};

  always @(posedge clock) begin
    rst_edge <= !resetN;
    cyc      <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
  endtask

  // Reference: data fills the non-power-of-two positions in order; parity p covers
  // every other position whose index has bit p set.
  function automatic logic [6:0] model(input logic [3:0] d, input bit odd,
                                       input bit inj, input logic [2:0] eb);
    logic [7:1] pos;
    logic       par;
    int         k;
    pos = '0;
    k   = 0;
    for (int j = 1; j <= 7; j++)
      if ((j & (j - 1)) != 0) begin
        pos[j] = d[k];
        k++;
      end
    for (int p = 1; p <= 4; p = p * 2) begin
      par = odd;
      for (int j = 1; j <= 7; j++)
        if ((j & p) != 0 && j != p) par = par ^ pos[j];
      pos[p] = par;
    end
    if (inj && eb != 0) pos[eb] = ~pos[eb];
    return pos;
  endfunction

  // Monitor for the main instance
  int mon_phase = 0;
  int mon_idx = 0;
  int mon_gap = 0;
  logic [6:0] mon_cur = '0;

  always @(negedge clock) begin
    if (rst_edge) begin
      chk("rst_outgoing", dataOutgoing, 0);
      chk("rst_dataout", dataOut, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_codeword", codeword, 0);
      chk("rst_ready", dataReady, resetN);
      mon_phase = 0;
    end else begin
      case (mon_phase)
        0: begin
          if (dataOutgoing) begin
            if (exp_q.size() == 0) begin
              fail("frame_without_accept");
              mon_cur = '0;
            end else mon_cur = exp_q.pop_front();
            chk("frame_codeword", codeword, mon_cur);
            chk("bit_value", dataOut, mon_cur[0]);
            chk("send_busy", busy, 1);
            chk("send_ready", dataReady, 0);
            mon_idx = 1;
            mon_phase = 1;
          end else begin
            chk("idle_dataout", dataOut, 0);
            chk("idle_done", done, 0);
          end
        end
        1: begin
          chk("bit_outgoing", dataOutgoing, 1);
          chk("bit_value", dataOut, mon_cur[mon_idx]);
          chk("held_codeword", codeword, mon_cur);
          chk("send_done", done, 0);
          chk("send_ready", dataReady, 0);
          mon_idx++;
          if (mon_idx == 7) mon_phase = 2;
        end
        2: begin
          chk("done_pulse", done, 1);
          chk("end_outgoing", dataOutgoing, 0);
          chk("end_dataout", dataOut, 0);
          chk("gap_busy", busy, 1);
          chk("gap_ready", dataReady, 0);
          mon_gap = 1;
          mon_phase = (mon_gap < G) ? 3 : 4;
        end
        3: begin
          chk("gap_outgoing", dataOutgoing, 0);
          chk("gap_done", done, 0);
          chk("gap_ready", dataReady, 0);
          chk("gap_busy", busy, 1);
          mon_gap++;
          if (mon_gap == G) mon_phase = 4;
        end
        default: begin
          chk("ready_after_gap", dataReady, 1);
          chk("idle_busy", busy, 0);
          chk("idle_outgoing", dataOutgoing, 0);
          chk("held_codeword", codeword, mon_cur);
          mon_phase = 0;
        end
      endcase
    end
  end

  task automatic offer(input logic [3:0] w, input logic inj, input logic [2:0] eb);
    @(posedge clock); #1;
    dataValid = 1'b1; dataWord = w; injectError = inj; errorBit = eb;
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (dataReady) begin
        exp_q.push_back(model(w, 1'b0, inj, eb));
        @(posedge clock); #1;
        dataValid = 1'b0; dataWord = 4'($urandom);
        injectError = 1'($urandom); errorBit = 3'($urandom);
        return;
      end
      @(posedge clock); #1;
    end
    fail("offer_timeout");
    dataValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(dataReady && !busy) && t < 64);
    if (t >= 64) fail("idle_timeout");
  endtask

  // Valid held high with a new word every cycle: only accepted words are expected
  task automatic hold_frames(input int n);
    int got = 0;
    int last = -1;
    int t = 0;
    logic [3:0] w;
    logic       inj;
    logic [2:0] eb;
    @(posedge clock); #1;
    dataValid = 1'b1;
    while (got < n && t < 400) begin
      w = 4'($urandom); inj = 1'($urandom); eb = 3'($urandom);
      dataWord = w; injectError = inj; errorBit = eb;
      @(negedge clock);
      if (dataReady) begin
        exp_q.push_back(model(w, 1'b0, inj, eb));
        if (last >= 0) chk("accept_spacing", cyc - last, 8 + G);
        last = cyc;
        got++;
      end
      @(posedge clock); #1;
      t++;
    end
    if (got < n) fail("hold_timeout");
    dataValid = 1'b0;
  endtask

  task automatic g0_test();
    int pos = -1;
    int nacc = 0;
    int last = -1;
    logic [6:0] c = '0;
    bit acc;
    @(posedge clock); #1;
    chk("g0_ready_in_reset", ready2, 0);
    rst2_n = 1'b1; v2 = 1'b1; w2 = g0_words[0];
    for (int t = 0; t < 30; t++) begin
      @(negedge clock);
      if (pos >= 0 && pos < 7) begin
        chk("g0_outgoing", outg2, 1);
        chk("g0_bit", out2, c[pos]);
        chk("g0_codeword", cw2, c);
        chk("g0_done", done2, 0);
        chk("g0_busy", busy2, 1);
        if (nacc == 1 && pos == 0) chk("g0_odd_zero", cw2, 7'b0001011);
      end else if (pos == 7) begin
        chk("g0_end_outgoing", outg2, 0);
        chk("g0_end_dataout", out2, 0);
        chk("g0_done_pulse", done2, 1);
        chk("g0_idle_busy", busy2, 0);
        chk("g0_idle_ready", ready2, 1);
      end
      acc = v2 && ready2;
      if (acc) begin
        c = model(w2, 1'b1, 1'b0, 3'd0);
        if (last >= 0) chk("g0_spacing", cyc - last, 8);
        last = cyc;
        nacc++;
        pos = 0;
      end else pos = (pos >= 0 && pos < 7) ? pos + 1 : -1;
      @(posedge clock); #1;
      if (acc) w2 = g0_words[nacc % 3];
    end
    v2 = 1'b0;
    chk("g0_frame_count", 32'(nacc >= 3), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; rst2_n = 1'b0; dataValid = 1'b0; dataWord = '0;
    injectError = 1'b0; errorBit = '0; v2 = 1'b0; w2 = '0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;

    offer(4'b1011, 1'b0, 3'd0); wait_idle(); chk("cw_1011", codeword, 7'b1010101);
    offer(4'b0000, 1'b0, 3'd0); wait_idle(); chk("cw_0000", codeword, 7'b0000000);
    offer(4'b1111, 1'b0, 3'd0); wait_idle(); chk("cw_1111", codeword, 7'b1111111);
    offer(4'b1011, 1'b1, 3'd3); wait_idle(); chk("cw_inj3", codeword, 7'b1010001);
    offer(4'b1011, 1'b1, 3'd0); wait_idle(); chk("cw_inj0", codeword, 7'b1010101);
    offer(4'b0000, 1'b1, 3'd7); wait_idle(); chk("cw_inj7", codeword, 7'b1000000);

    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      offer(4'($urandom), 1'($urandom), 3'($urandom));
    end
    wait_idle();

    hold_frames(4);
    wait_idle();

    // Abort a frame while bit 3 is on the wire
    offer(4'($urandom), 1'b0, 3'd0);
    repeat (3) begin @(posedge clock); #1; end
    resetN = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    resetN = 1'b1;
    offer(4'b1011, 1'b0, 3'd0); wait_idle(); chk("cw_after_reset", codeword, 7'b1010101);

    g0_test();

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
